// File: rtl/spi_target.sv
// SPI target (slave) with an RX FIFO and a TX holding register on the CPU register bus.
// CPHA is fixed at 0: MOSI is sampled on the leading SCK edge and MISO changes on the trailing edge.
// All SPI pins are synchronised into clk, so clk must run at least 4x SCK.
module spi_target #(
  parameter bit          CPOL       = 1'b0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  FILL       = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  we,
  input  logic        rd,
  input  logic        select,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        wbusy,
  output logic        rbusy,
  output logic        irq,
  input  logic        spi_clk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2:0]    sck_q, ss_q;
  logic [1:0]    mosi_q;
  logic          active_q, active_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [6:0]    shift_in_q, shift_in_d;
  logic [7:0]    shift_out_q, shift_out_d;
  logic          load_next_q, load_next_d;
  logic [7:0]    tx_reg_q, tx_reg_d;
  logic          tx_pend_q, tx_pend_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic lead, trail, ss_fall, ss_rise, mosi_s;
  logic push, push_ok, pop, full, not_empty, tx_take, cpu_tx_wr, flag_wr;
  logic [7:0] rx_byte, head_byte;
  logic [4:0] rx_count;
  logic unused_bits;

  assign mosi_s    = mosi_q[1];
  assign lead      = (sck_q[1] != sck_q[2]) && (sck_q[1] != CPOL);
  assign trail     = (sck_q[1] != sck_q[2]) && (sck_q[1] == CPOL);
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign rx_byte   = {shift_in_q, mosi_s};
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign not_empty = (count_q != '0);
  assign pop       = select & rd & (addr == 2'd0) & not_empty;
  assign cpu_tx_wr = select & we[0] & (addr == 2'd1);
  assign flag_wr   = select & we[3] & (addr == 2'd2);
  assign push_ok   = push & (~full | pop);
  assign rx_count  = 5'(count_q);
  assign head_byte = not_empty ? mem[rptr_q] : 8'h00;

  assign spi_miso    = shift_out_q[7];
  assign spi_miso_oe = active_q;
  assign irq         = not_empty;
  assign wbusy       = 1'b0;
  assign rbusy       = 1'b0;
  assign unused_bits = ^{we[2:1], wdata[31:26], wdata[23:8]};

  // Pin synchronisers; SS_n resets to "selected" so a low pin after reset gives no false frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= {3{CPOL}};
      ss_q   <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clk};
      ss_q   <= {ss_q[1:0], spi_ss_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  // Next-state for the shifter, TX holding register, sticky flags and FIFO pointers.
  always_comb begin
    active_d    = active_q;
    bitcnt_d    = bitcnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    load_next_d = load_next_q;
    tx_reg_d    = tx_reg_q;
    tx_pend_d   = tx_pend_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    push        = 1'b0;
    tx_take     = 1'b0;

    if (ss_rise) begin
      active_d    = 1'b0;
      bitcnt_d    = 3'd0;
      load_next_d = 1'b0;
    end else if (ss_fall) begin
      active_d    = 1'b1;
      bitcnt_d    = 3'd0;
      shift_in_d  = 7'd0;
      load_next_d = 1'b0;
      tx_take     = 1'b1;
    end else if (active_q) begin
      if (lead) begin
        shift_in_d = rx_byte[6:0];
        bitcnt_d   = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          push        = 1'b1;
          load_next_d = 1'b1;
        end
      end else if (trail) begin
        if (load_next_q) begin
          tx_take     = 1'b1;
          load_next_d = 1'b0;
        end else begin
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
    end

    // Load takes the old holding byte; a CPU write in the same cycle stays pending.
    if (tx_take) begin
      shift_out_d = tx_pend_q ? tx_reg_q : FILL;
      tx_pend_d   = 1'b0;
    end
    if (cpu_tx_wr) begin
      tx_reg_d  = wdata[7:0];
      tx_pend_d = 1'b1;
    end

    // Sticky flags: set beats a same-cycle write-1-to-clear.
    overrun_d  = (overrun_q & ~(flag_wr & wdata[24])) | (push & full & ~pop);
    underrun_d = (underrun_q & ~(flag_wr & wdata[25])) | (tx_take & ~tx_pend_q);

    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop)     rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= 1'b0;
      bitcnt_q    <= 3'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= FILL;
      load_next_q <= 1'b0;
      tx_reg_q    <= 8'h00;
      tx_pend_q   <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      active_q    <= active_d;
      bitcnt_q    <= bitcnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      load_next_q <= load_next_d;
      tx_reg_q    <= tx_reg_d;
      tx_pend_q   <= tx_pend_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; emptiness is tracked by the pointers so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= rx_byte;
  end

  // Register read mux.
  always_comb begin
    rdata = 32'h0;
    case (addr)
      2'd0:    rdata = {23'b0, not_empty, head_byte};
      2'd1:    rdata = {23'b0, tx_pend_q, tx_reg_q};
      2'd2:    rdata = {6'b0, underrun_q, overrun_q, 7'b0, active_q, 7'b0, tx_pend_q, 3'b0,
                        rx_count};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: CPOL=0, SCK at 1/8 of clk, all stimulus on clk falling edges.
module tb_spi_target;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  we = 4'h0;
  logic        rd = 1'b0;
  logic        select = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        wbusy, rbusy, irq;
  logic        spi_clk = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;

  int passed = 0;
  int failed = 0;
  int total = 0;

  spi_target #(
    .CPOL(1'b0),
    .FIFO_DEPTH(4),
    .FILL(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .rd(rd),
    .select(select),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .wbusy(wbusy),
    .rbusy(rbusy),
    .irq(irq),
    .spi_clk(spi_clk),
    .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    select = 1'b1; addr = a; we = be; wdata = d;
    @(negedge clk);
    select = 1'b0; we = 4'h0; wdata = 32'h0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    select = 1'b1; rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    select = 1'b0; rd = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    check(tag, d, exp);
  endtask

  // Shift nbits of tx MSB first; optionally pop addr 0 in the cycle the last bit is pushed.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit pop_last,
                          input logic [31:0] pop_exp, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      rx = {rx[6:0], spi_miso};
      if (pop_last && i == nbits - 1) begin
        repeat (2) @(negedge clk);
        select = 1'b1; rd = 1'b1; addr = 2'd0;
        #1 check("pop_with_push", rdata, pop_exp);
        @(negedge clk);
        select = 1'b0; rd = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (8) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_oe", {31'b0, spi_miso_oe}, 32'h0);
    check("rst_miso", {31'b0, spi_miso}, 32'h1);
    check("rst_busy", {30'b0, wbusy, rbusy}, 32'h0);
    read_check("rst_rx", 2'd0, 32'h0);
    read_check("rst_tx", 2'd1, 32'h0);
    read_check("rst_status", 2'd2, 32'h0);
    read_check("rst_addr3", 2'd3, 32'h0);

    // Single byte exchange: A5 out, 3C in
    cpu_write(2'd1, 4'b0001, 32'h0000_00A5);
    read_check("t1_tx_reg", 2'd1, 32'h0000_01A5);
    frame_begin();
    check("t1_oe", {31'b0, spi_miso_oe}, 32'h1);
    spi_bits(8'h3C, 8, 1'b0, 32'h0, rx);
    check("t1_miso", {24'b0, rx}, 32'hA5);
    frame_end();
    check("t1_irq", {31'b0, irq}, 32'h1);
    read_check("t1_rx", 2'd0, 32'h0000_013C);
    check("t1_irq_after", {31'b0, irq}, 32'h0);
    // After the 8th bit the next load found nothing pending
    read_check("t1_status", 2'd2, 32'h0200_0000);
    cpu_write(2'd2, 4'b1000, 32'h0200_0000);
    read_check("t1_clr", 2'd2, 32'h0);

    // Three bytes with one pending TX byte
    cpu_write(2'd1, 4'b0001, 32'h0000_0011);
    frame_begin();
    spi_bits(8'h01, 8, 1'b0, 32'h0, rx);
    check("t2_miso0", {24'b0, rx}, 32'h11);
    spi_bits(8'h02, 8, 1'b0, 32'h0, rx);
    check("t2_miso1", {24'b0, rx}, 32'hFF);
    spi_bits(8'h03, 8, 1'b0, 32'h0, rx);
    check("t2_miso2", {24'b0, rx}, 32'hFF);
    frame_end();
    read_check("t2_status", 2'd2, 32'h0200_0003);
    read_check("t2_pop0", 2'd0, 32'h0000_0101);
    read_check("t2_pop1", 2'd0, 32'h0000_0102);
    read_check("t2_pop2", 2'd0, 32'h0000_0103);
    cpu_write(2'd2, 4'b1000, 32'h0200_0000);
    read_check("t2_clr", 2'd2, 32'h0);

    // Five bytes into a depth-4 FIFO: overrun, fifth byte lost
    frame_begin();
    for (int b = 0; b < 5; b++) spi_bits(8'(8'h21 + b), 8, 1'b0, 32'h0, rx);
    frame_end();
    read_check("t3_status", 2'd2, 32'h0300_0004);
    read_check("t3_pop0", 2'd0, 32'h0000_0121);
    read_check("t3_pop1", 2'd0, 32'h0000_0122);
    read_check("t3_pop2", 2'd0, 32'h0000_0123);
    read_check("t3_pop3", 2'd0, 32'h0000_0124);
    begin
      logic [31:0] d;
      cpu_read(2'd0, d);
      check("t3_empty_valid", {31'b0, d[8]}, 32'h0);
    end
    cpu_write(2'd2, 4'b1000, 32'h0300_0000);
    read_check("t3_clr", 2'd2, 32'h0);

    // Same, but pop coincides with the fifth push: no overrun
    frame_begin();
    for (int b = 0; b < 4; b++) spi_bits(8'(8'h31 + b), 8, 1'b0, 32'h0, rx);
    spi_bits(8'h35, 8, 1'b1, 32'h0000_0131, rx);
    frame_end();
    read_check("t4_status", 2'd2, 32'h0200_0004);
    read_check("t4_pop0", 2'd0, 32'h0000_0132);
    read_check("t4_pop1", 2'd0, 32'h0000_0133);
    read_check("t4_pop2", 2'd0, 32'h0000_0134);
    read_check("t4_pop3", 2'd0, 32'h0000_0135);
    cpu_write(2'd2, 4'b1000, 32'h0300_0000);

    // Partial byte discarded, then a full 0x77
    frame_begin();
    spi_bits(8'hAA, 5, 1'b0, 32'h0, rx);
    frame_end();
    read_check("t5_partial", 2'd2, 32'h0200_0000);
    frame_begin();
    spi_bits(8'h77, 8, 1'b0, 32'h0, rx);
    frame_end();
    read_check("t5_status", 2'd2, 32'h0200_0001);
    read_check("t5_pop", 2'd0, 32'h0000_0177);
    read_check("t5_empty", 2'd2, 32'h0200_0000);
    cpu_write(2'd2, 4'b1000, 32'h0200_0000);

    // Reset in the middle of a byte
    cpu_write(2'd1, 4'b0001, 32'h0000_0099);
    frame_begin();
    spi_bits(8'h44, 8, 1'b0, 32'h0, rx);
    check("t6_miso_pre", {24'b0, rx}, 32'h99);
    spi_bits(8'h00, 3, 1'b0, 32'h0, rx);
    check("t6_irq_pre", {31'b0, irq}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_oe", {31'b0, spi_miso_oe}, 32'h0);
    check("t6_irq", {31'b0, irq}, 32'h0);
    check("t6_miso", {31'b0, spi_miso}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    read_check("t6_status", 2'd2, 32'h0);
    read_check("t6_tx", 2'd1, 32'h0);
    // Rest of the interrupted byte must not be resumed
    spi_bits(8'h00, 5, 1'b0, 32'h0, rx);
    read_check("t6_no_resume", 2'd2, 32'h0);
    frame_end();
    frame_begin();
    spi_bits(8'h6B, 8, 1'b0, 32'h0, rx);
    check("t6_miso_fill", {24'b0, rx}, 32'hFF);
    frame_end();
    read_check("t6_pop", 2'd0, 32'h0000_016B);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
